// File: rtl/video_timing_pkg.sv
// Shared types, default 640x480@60 geometry and geometry helpers for the raster timing generator.
// No logic of its own; used at elaboration by video_timing_gen.
// Not applicable (no datapath).
package video_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Default 640x480@60 geometry (25 MHz pixel clock from 100 MHz)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;

  // Total line/frame length from its four region widths
  function automatic int region_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // True when every region is non-empty, the divider is at least 1 and the
  // counters are wide enough to hold the last column/row.
  function automatic bit geometry_ok(input int h_active, input int h_fp,
                                     input int h_sync, input int h_bp,
                                     input int v_active, input int v_fp,
                                     input int v_sync, input int v_bp,
                                     input int clk_div, input int xw, input int yw);
    int h_total;
    int v_total;
    bit ok;
    h_total = region_total(h_active, h_fp, h_sync, h_bp);
    v_total = region_total(v_active, v_fp, v_sync, v_bp);
    ok = (h_active > 0) && (h_fp > 0) && (h_sync > 0) && (h_bp > 0) &&
         (v_active > 0) && (v_fp > 0) && (v_sync > 0) && (v_bp > 0) &&
         (clk_div >= 1) && (xw > 0) && (yw > 0) && (xw < 32) && (yw < 32);
    if (ok) begin
      ok = ((longint'(1) << xw) >= longint'(h_total)) &&
           ((longint'(1) << yw) >= longint'(v_total));
    end
    return ok;
  endfunction

endpackage

// File: rtl/video_timing_gen_pixel_tick_gen.sv
// Pixel-clock divider: pix_tick is high for one clk every CLK_DIV clks while not held.
// Latency: pix_tick registered; tick_next is its combinational look-ahead.
// No backpressure; hold forces the phase counter to 0.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hold,
  input  logic run_next,
  output logic pix_tick,
  output logic tick_next
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Next phase: held at 0 while idle, otherwise counts 0..CLK_DIV-1 and wraps
  always_comb begin
    cnt_next = '0;
    if (!hold && (cnt != LAST)) begin
      cnt_next = cnt + CW'(1);
    end
    tick_next = run_next && (cnt_next == LAST);
  end

  // Phase counter and registered tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      pix_tick <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      pix_tick <= tick_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y scan, syncs, active/blank decode and line/frame strobes.
// Latency: all outputs registered; decodes always match the x,y shown in the same cycle.
// No backpressure; en starts on the next edge and stops only at the end of a frame.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int XW        = 10,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank,
  output logic          running
);

  localparam int H_TOTAL = region_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = region_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (!geometry_ok(H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP,
                   CLK_DIV, XW, YW)) begin : g_bad_geometry
    $error("video_timing_gen: invalid geometry, divider or counter width");
  end

  logic [1:0] rst_pipe;
  logic       rst_n_int;

  state_t  state;
  state_t  state_next;
  logic    last_pix;
  logic    run_next;
  logic    tick_next;

  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          video_on_next;
  logic          vblank_next;
  logic          line_start_next;
  logic          frame_start_next;

  // Reset synchroniser: assertion passes straight through, release waits two clks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n_int = rst_pipe[1];

  // State register
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign last_pix = pix_tick && (x == X_LAST) && (y == Y_LAST);

  // Next state: en is honoured at once when starting or resuming, a stop
  // request only takes effect once the last pixel of the frame is consumed
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if (en) state_next = RUN;
               else if (last_pix) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign run_next = (state_next != IDLE);

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk       (clk),
    .reset_n   (rst_n_int),
    .hold      (state == IDLE),
    .run_next  (run_next),
    .pix_tick  (pix_tick),
    .tick_next (tick_next)
  );

  // Output decode of the upcoming x,y so every registered output agrees with it
  always_comb begin
    x_next = x;
    y_next = y;
    if (state == IDLE) begin
      x_next = '0;
      y_next = '0;
    end else if (pix_tick) begin
      if (x == X_LAST) begin
        x_next = '0;
        y_next = (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x_next = x + XW'(1);
      end
    end
    hsync_next       = ((x_next >= HS_BEG) && (x_next <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next       = ((y_next >= VS_BEG) && (y_next <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    video_on_next    = run_next && (x_next < X_ACT) && (y_next < Y_ACT);
    vblank_next      = (y_next >= Y_ACT);
    line_start_next  = tick_next && (x_next == '0);
    frame_start_next = tick_next && (x_next == '0) && (y_next == '0) && (state_next == RUN);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      x           <= '0;
      y           <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      video_on    <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      x           <= x_next;
      y           <= y_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      video_on    <= video_on_next;
      vblank      <= vblank_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
      running     <= run_next;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance (a_*) and small 14x7 instance (b_*).
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b, en_a, en_b;

  logic [9:0] a_x, a_y;
  logic a_hsync, a_vsync, a_video_on, a_pix_tick, a_line_start, a_frame_start, a_vblank, a_running;
  logic [3:0] b_x;
  logic [2:0] b_y;
  logic b_hsync, b_vsync, b_video_on, b_pix_tick, b_line_start, b_frame_start, b_vblank, b_running;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  video_timing_gen u_a (
    .clk(clk), .reset_n(rst_a), .en(en_a), .x(a_x), .y(a_y),
    .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on), .pix_tick(a_pix_tick),
    .line_start(a_line_start), .frame_start(a_frame_start), .vblank(a_vblank),
    .running(a_running)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .XW(4), .YW(3)
  ) u_b (
    .clk(clk), .reset_n(rst_b), .en(en_b), .x(b_x), .y(b_y),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on), .pix_tick(b_pix_tick),
    .line_start(b_line_start), .frame_start(b_frame_start), .vblank(b_vblank),
    .running(b_running)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  w;
    int  xe, ye, ticks;
    longint t_line, t_fs;

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values, en already high on A
    check_eq("a_rst_x", a_x, 0);
    check_eq("a_rst_y", a_y, 0);
    check_eq("a_rst_hsync", a_hsync, 1);
    check_eq("a_rst_vsync", a_vsync, 1);
    check_eq("a_rst_video_on", a_video_on, 0);
    check_eq("a_rst_pix_tick", a_pix_tick, 0);
    check_eq("a_rst_running", a_running, 0);
    check_eq("a_rst_line_start", a_line_start, 0);
    check_eq("a_rst_frame_start", a_frame_start, 0);
    check_eq("a_rst_vblank", a_vblank, 0);
    check_eq("b_rst_hsync", b_hsync, 0);
    check_eq("b_rst_vsync", b_vsync, 0);

    // Release A; first tick lands in the 4th running cycle at (0,0)
    rst_a = 1'b1;
    w = 0;
    while (!a_running && w < 8) begin @(negedge clk); w++; end
    check_eq("a_running_rise", a_running, 1);
    for (int k = 1; k <= 3; k++) begin
      check_eq("a_first_tick_wait", a_pix_tick, 0);
      @(negedge clk);
    end
    check_eq("a_first_tick", a_pix_tick, 1);
    check_eq("a_first_frame_start", a_frame_start, 1);
    check_eq("a_first_line_start", a_line_start, 1);
    check_eq("a_first_x", a_x, 0);
    check_eq("a_first_y", a_y, 0);
    check_eq("a_first_video_on", a_video_on, 1);
    t_line = $time;

    // One full line at the default geometry: 4-clk tick period, hsync 656..751
    for (int p = 1; p <= 800; p++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c < 4) check_eq("a_tick_gap", a_pix_tick, 0);
      end
      xe = p % 800;
      ye = p / 800;
      check_eq("a_tick", a_pix_tick, 1);
      check_eq("a_x", a_x, xe);
      check_eq("a_y", a_y, ye);
      check_eq("a_hsync", a_hsync, (xe >= 656 && xe <= 751) ? 0 : 1);
      check_eq("a_video_on", a_video_on, (xe < 640) ? 1 : 0);
      check_eq("a_line_start", a_line_start, (xe == 0) ? 1 : 0);
    end
    check_eq("a_line_period", 32'((($time - t_line) / 10)), 3200);
    check_eq("a_line1_frame_start", a_frame_start, 0);
    check_eq("a_line1_vsync", a_vsync, 1);
    check_eq("a_line1_vblank", a_vblank, 0);

    // Advance to x=300 on line 1, then assert reset between clock edges
    for (int p = 1; p <= 300; p++) repeat (4) @(negedge clk);
    check_eq("a_pre_rst_x", a_x, 300);
    check_eq("a_pre_rst_y", a_y, 1);
    check_eq("a_pre_rst_video_on", a_video_on, 1);
    check_eq("a_pre_rst_tick", a_pix_tick, 1);
    #1 rst_a = 1'b0;
    #1;
    check_eq("a_async_x", a_x, 0);
    check_eq("a_async_y", a_y, 0);
    check_eq("a_async_video_on", a_video_on, 0);
    check_eq("a_async_tick", a_pix_tick, 0);
    check_eq("a_async_running", a_running, 0);
    check_eq("a_async_hsync", a_hsync, 1);
    check_eq("a_async_line_start", a_line_start, 0);
    @(negedge clk);
    rst_a = 1'b1;
    w = 0;
    while (!a_running && w < 8) begin @(negedge clk); w++; end
    check_eq("a_restart_running", a_running, 1);
    repeat (3) @(negedge clk);
    check_eq("a_restart_tick", a_pix_tick, 1);
    check_eq("a_restart_frame_start", a_frame_start, 1);
    check_eq("a_restart_x", a_x, 0);
    check_eq("a_restart_y", a_y, 0);

    // Small instance: stays idle with en low after release
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("b_idle_running", b_running, 0);
    check_eq("b_idle_tick", b_pix_tick, 0);
    check_eq("b_idle_x", b_x, 0);

    // Four frames: glitch en in frame 3, request stop at (3,2) of frame 4
    en_b = 1'b1;
    @(negedge clk);
    t_fs = -1;
    for (int n = 0; n < 392; n++) begin
      xe = n % 14;
      ye = (n / 14) % 7;
      check_eq("b_tick", b_pix_tick, 1);
      check_eq("b_running", b_running, 1);
      check_eq("b_x", b_x, xe);
      check_eq("b_y", b_y, ye);
      check_eq("b_x_max", (b_x <= 13) ? 1 : 0, 1);
      check_eq("b_hsync", b_hsync, (xe >= 10 && xe <= 11) ? 1 : 0);
      check_eq("b_vsync", b_vsync, (ye == 5) ? 1 : 0);
      check_eq("b_video_on", b_video_on, (xe < 8 && ye < 4) ? 1 : 0);
      check_eq("b_vblank", b_vblank, (ye >= 4) ? 1 : 0);
      check_eq("b_line_start", b_line_start, (xe == 0) ? 1 : 0);
      check_eq("b_frame_start", b_frame_start, (xe == 0 && ye == 0) ? 1 : 0);
      if (b_frame_start) begin
        if (t_fs >= 0) check_eq("b_frame_period", 32'((($time - t_fs) / 10)), 98);
        t_fs = $time;
      end
      if (n == 226) en_b = 1'b0;
      if (n == 236) en_b = 1'b1;
      if (n == 325) en_b = 1'b0;
      @(negedge clk);
    end

    // Stopped after the tick at (13,6): idle, no further ticks
    check_eq("b_stop_running", b_running, 0);
    check_eq("b_stop_tick", b_pix_tick, 0);
    check_eq("b_stop_x", b_x, 0);
    check_eq("b_stop_y", b_y, 0);
    check_eq("b_stop_video_on", b_video_on, 0);
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (b_pix_tick) ticks++;
    end
    check_eq("b_stop_no_ticks", ticks, 0);
    check_eq("b_stop_still_idle", b_running, 0);

    // Restart from (0,0) with frame_start
    en_b = 1'b1;
    @(negedge clk);
    check_eq("b_restart_running", b_running, 1);
    check_eq("b_restart_tick", b_pix_tick, 1);
    check_eq("b_restart_frame_start", b_frame_start, 1);
    check_eq("b_restart_x", b_x, 0);
    check_eq("b_restart_y", b_y, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
